// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed scan controller for a 4-digit common-anode
// 7-segment display.
//
// Each digit slot has two phases. It starts with GAP_CYCLES blanked cycles and
// then shows the selected digit for the rest of the slot. digit_sel advances
// only when a new slot begins, so the anode switches while the segments are
// dark. New values are double-buffered: a load fills the shadow registers, and
// the shadow is copied to the active registers only at the digit 3 -> 0 wrap.
//
// Parameters:
//   DIGIT_CYCLES  clock cycles per digit slot (>= 2)
//   GAP_CYCLES    blanked cycles at the start of each slot (1..DIGIT_CYCLES-1)
// Ports:
//   clk, rst_n    clock; synchronous active-low reset
//   value_in[15:0] four hex nibbles; nibble i feeds digit i
//   dp_in[3:0]    decimal point per digit (1 = lit)
//   load          one-cycle strobe that captures value_in/dp_in into the shadow
//   pending       shadow holds a value that has not been applied yet
//   digit_sel[1:0] digit index for the 2-to-4 anode decoder
//   digit_on      high during the show phase
//   seg_n[6:0]    segments {g,f,e,d,c,b,a}, active-low
//   dp_n          decimal point, active-low
//   frame_tick    one-cycle pulse after the digit 3 -> 0 wrap
// Configuration:
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits (3..1) are blanked
//                          during the show phase
module display_scanner #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int GAP_CYCLES   = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        pending,
  output logic [1:0]  digit_sel,
  output logic        digit_on,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_tick
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_C = CW'(GAP_CYCLES);

  localparam logic [0:0] ST_GAP  = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  logic [CW-1:0] cnt, cnt_nxt;
  logic [0:0]    state, state_nxt;
  logic [1:0]    sel_nxt;
  logic [15:0]   act_val, sh_val, act_val_nxt;
  logic [3:0]    act_dp, sh_dp, act_dp_nxt;
  logic [3:0]    nib;
  logic [6:0]    seg_nxt;
  logic          dp_nxt, pend_nxt, last, wrap;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Outputs are registered from the next-state values so they change on the
  // same edge as the counter and state.
  always_comb begin
    last        = (cnt == LAST);
    wrap        = last && (digit_sel == 2'd3);
    cnt_nxt     = last ? '0 : cnt + 1'b1;
    state_nxt   = (cnt_nxt >= GAP_C) ? ST_SHOW : ST_GAP;
    sel_nxt     = last ? digit_sel + 2'd1 : digit_sel;
    act_val_nxt = (wrap && pending) ? sh_val : act_val;
    act_dp_nxt  = (wrap && pending) ? sh_dp  : act_dp;
    // A load on the wrap cycle keeps pending set for the next frame.
    pend_nxt    = load | (pending & ~wrap);
    nib         = act_val_nxt[{sel_nxt, 2'b00} +: 4];
    seg_nxt     = 7'h7F;
    dp_nxt      = 1'b1;
    if (state_nxt == ST_SHOW) begin
      seg_nxt = hex7(nib);
      dp_nxt  = ~act_dp_nxt[sel_nxt];
`ifdef LEADING_ZERO_BLANK_EN
      // Blank this digit if it and every higher nibble are zero; digit 0 stays.
      if (sel_nxt != 2'd0 && (act_val_nxt >> {sel_nxt, 2'b00}) == 16'h0000)
        seg_nxt = 7'h7F;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      state      <= ST_GAP;
      digit_sel  <= 2'd0;
      act_val    <= '0;
      act_dp     <= '0;
      sh_val     <= '0;
      sh_dp      <= '0;
      pending    <= 1'b0;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      state      <= state_nxt;
      digit_sel  <= sel_nxt;
      act_val    <= act_val_nxt;
      act_dp     <= act_dp_nxt;
      pending    <= pend_nxt;
      seg_n      <= seg_nxt;
      dp_n       <= dp_nxt;
      frame_tick <= wrap;
      if (load) begin
        sh_val <= value_in;
        sh_dp  <= dp_in;
      end
    end
  end

  assign digit_on = (state == ST_SHOW);

endmodule

// File: tb/tb_display_scanner.sv
module tb_display_scanner;
  localparam int DC = 8;
  localparam int GC = 2;
  localparam int FRAME = 4 * DC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        pending, digit_on, dp_n, frame_tick;
  logic [1:0]  digit_sel;
  logic [6:0]  seg_n;

  display_scanner #(.DIGIT_CYCLES(DC), .GAP_CYCLES(GC)) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .dp_in(dp_in), .load(load),
    .pending(pending), .digit_sel(digit_sel), .digit_on(digit_on),
    .seg_n(seg_n), .dp_n(dp_n), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: cycle index since reset plus frame-level buffers.
  int          c;
  logic [15:0] m_val, m_sh_val;
  logic [3:0]  m_dp, m_sh_dp;
  logic        m_pend;
  int          n_vec = 0;
  int          n_bad = 0;

  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // {digit_sel, digit_on, seg_n, dp_n, frame_tick, pending}
  function automatic logic [12:0] exp_out();
    int pos, dig;
    logic show;
    logic [6:0] s;
    logic d;
    pos  = c % DC;
    dig  = (c / DC) % 4;
    show = (pos >= GC);
    s    = 7'h7F;
    d    = 1'b1;
    if (show) begin
      s = pat[(m_val >> (4 * dig)) & 16'hF];
      d = ~m_dp[dig];
`ifdef LEADING_ZERO_BLANK_EN
      if (dig > 0 && (m_val >> (4 * dig)) == 0) s = 7'h7F;
`endif
    end
    return {2'(dig), show, s, d, (c % FRAME == 0) && (c != 0), m_pend};
  endfunction

  function automatic logic [12:0] obs_out();
    return {digit_sel, digit_on, seg_n, dp_n, frame_tick, pending};
  endfunction

  task automatic tick(input bit r, input bit ld, input logic [15:0] v, input logic [3:0] d);
    bit wrap;
    rst_n = !r; load = ld; value_in = v; dp_in = d;
    @(posedge clk);
    if (r) begin
      c = 0; m_val = '0; m_dp = '0; m_sh_val = '0; m_sh_dp = '0; m_pend = 1'b0;
    end else begin
      wrap = (c % FRAME == FRAME - 1);
      if (wrap && m_pend) begin m_val = m_sh_val; m_dp = m_sh_dp; end
      if (ld) begin m_sh_val = v; m_sh_dp = d; m_pend = 1'b1; end
      else if (wrap) m_pend = 1'b0;
      c++;
    end
    #1;
    rst_n = 1'b1; load = 1'b0;
  endtask

  // Idle until the model's frame position equals pos (bounded to one frame).
  task automatic run_to(input int pos);
    for (int i = 0; i < FRAME && (c % FRAME) != pos; i++) tick(0, 0, '0, '0);
  endtask

  task automatic test_reset();
    tick(1, 0, '0, '0);
    tick(1, 0, '0, '0);
    n_vec++;
    if (obs_out() !== 13'b00_0_1111111_1_0_0) begin
      n_bad++;
      $display("FAIL reset got %h want %h", obs_out(), 13'b00_0_1111111_1_0_0);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      tick(0, 0, '0, '0);
      n_vec++;
      if (obs_out() !== exp_out()) begin
        n_bad++;
        $display("FAIL idle c=%0d got %h want %h", c, obs_out(), exp_out());
      end
    end
  endtask

  task automatic test_load_mid();
    run_to(13);
    tick(0, 1, 16'h1A3F, 4'b0100);
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(0, 0, '0, '0);
      n_vec++;
      if (obs_out() !== exp_out()) begin
        n_bad++;
        $display("FAIL load_mid c=%0d got %h want %h", c, obs_out(), exp_out());
      end
      // Fixed-value spot check: digit 2 in show of the frame after the wrap.
      if (c % FRAME == 2 * DC + GC + 1 && i > FRAME / 2) begin
        n_vec++;
        if (seg_n !== 7'h08 || dp_n !== 1'b0 || pending !== 1'b0) begin
          n_bad++;
          $display("FAIL load_mid_d2 got seg=%h dp_n=%b pend=%b want 08 0 0", seg_n, dp_n, pending);
        end
      end
    end
  endtask

  task automatic test_double_load();
    run_to(3);
    tick(0, 1, 16'h1111, 4'b0000);
    run_to(20);
    tick(0, 1, 16'h2222, 4'b0000);
    for (int i = 0; i < FRAME + 16; i++) begin
      tick(0, 0, '0, '0);
      n_vec++;
      if (obs_out() !== exp_out()) begin
        n_bad++;
        $display("FAIL double_load c=%0d got %h want %h", c, obs_out(), exp_out());
      end
      if (c % FRAME >= GC && c % DC >= GC && pending === 1'b0) begin
        n_vec++;
        if (seg_n !== 7'h24) begin
          n_bad++;
          $display("FAIL double_load_seg got %h want 24", seg_n);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    run_to(10);
    tick(0, 1, 16'h4567, 4'b1001);
    run_to(FRAME - 1);
    tick(0, 1, 16'h89AB, 4'b0110);
    n_vec++;
    if (pending !== 1'b1 || frame_tick !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_load got pend=%b tick=%b want 1 1", pending, frame_tick);
    end
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      tick(0, 0, '0, '0);
      n_vec++;
      if (obs_out() !== exp_out()) begin
        n_bad++;
        $display("FAIL wrap_load c=%0d got %h want %h", c, obs_out(), exp_out());
      end
    end
  endtask

  task automatic test_reset_mid();
    run_to(0);
    tick(0, 0, '0, '0);
    tick(0, 1, 16'hFEDC, 4'b1111);
    run_to(2 * DC + GC + 2);
    tick(1, 0, '0, '0);
    n_vec++;
    if (digit_sel !== 2'd0 || seg_n !== 7'h7F || pending !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid got sel=%0d seg=%h pend=%b want 0 7f 0", digit_sel, seg_n, pending);
    end
    for (int i = 0; i < FRAME + 8; i++) begin
      tick(0, 0, '0, '0);
      n_vec++;
      if (obs_out() !== exp_out()) begin
        n_bad++;
        $display("FAIL reset_mid c=%0d got %h want %h", c, obs_out(), exp_out());
      end
    end
  endtask

  task automatic test_lzb();
    tick(0, 1, 16'h0050, 4'b0000);
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(0, 0, '0, '0);
      n_vec++;
      if (obs_out() !== exp_out()) begin
        n_bad++;
        $display("FAIL lzb c=%0d got %h want %h", c, obs_out(), exp_out());
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int i = 0; i < 600; i++) begin
      v = 16'($urandom);
      if ($urandom_range(0, 2) == 0) v = v & (16'hFFFF >> (4 * $urandom_range(1, 3)));
      if ($urandom_range(0, 250) == 0) tick(1, 0, '0, '0);
      else tick(0, $urandom_range(0, 15) == 0, v, 4'($urandom));
      n_vec++;
      if (obs_out() !== exp_out()) begin
        n_bad++;
        $display("FAIL random c=%0d got %h want %h", c, obs_out(), exp_out());
      end
    end
  endtask

  initial begin
    c = 0; m_val = '0; m_dp = '0; m_sh_val = '0; m_sh_dp = '0; m_pend = 1'b0;
    test_reset();
    test_idle();
    test_load_mid();
    test_double_load();
    test_back_to_back();
    test_reset_mid();
    test_lzb();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
